// File: rtl/bus_dma_pkg.sv
// bus_dma_pkg: shared constants for the single-channel bus DMA master.
// FSM state codes and default bus/count widths.
package bus_dma_pkg;

   localparam int ADDR_W_DEF    = 16;
   localparam int DATA_W_DEF    = 64;
   localparam int LEN_W_DEF     = 8;
   localparam int ADDR_STEP_DEF = 1;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_RD   = 3'd2;
   localparam logic [2:0] ST_RDW  = 3'd3;
   localparam logic [2:0] ST_WR   = 3'd4;
   localparam logic [2:0] ST_DONE = 3'd5;

endpackage

// File: rtl/bus_dma_master_if.sv
// bus_dma_master_if: master-side bus bundle (req/wr/addr/data/grant).
// Master drives the request; the bus fabric returns grant and read data.
interface bus_dma_master_if
   import bus_dma_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              m_req;
   logic              m_wr;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_dout;
   logic              m_grant;
   logic [DATA_W-1:0] m_din;

   modport master (
      output m_req, m_wr, m_addr, m_dout,
      input  m_grant, m_din
   );

   modport slave (
      input  m_req, m_wr, m_addr, m_dout,
      output m_grant, m_din
   );

endinterface

// File: rtl/bus_dma_addr_cnt.sv
// bus_dma_addr_cnt: current source/destination pointers and word count.
// Loaded on job start, stepped once per completed write.
module bus_dma_addr_cnt
   import bus_dma_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int LEN_W     = LEN_W_DEF,
   parameter int ADDR_STEP = ADDR_STEP_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_load,
   input  logic              i_step,
   input  logic [ADDR_W-1:0] i_src,
   input  logic [ADDR_W-1:0] i_dst,
   input  logic [LEN_W-1:0]  i_len,
   output logic [ADDR_W-1:0] o_src,
   output logic [ADDR_W-1:0] o_dst,
   output logic              o_zero_nxt
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [LEN_W-1:0]  r_cnt;

   // load operands on start, advance both pointers on each word written
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_src <= '0;
         r_dst <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_src <= i_src;
         r_dst <= i_dst;
         r_cnt <= i_len;
      end else if (i_step) begin
         r_src <= r_src + STEP;
         r_dst <= r_dst + STEP;
         r_cnt <= r_cnt - LEN_W'(1);
      end
   end

   assign o_src      = r_src;
   assign o_dst      = r_dst;
   // count reaches zero on the next step: this write is the last one
   assign o_zero_nxt = (r_cnt == LEN_W'(1));

endmodule

// File: rtl/bus_dma_master.sv
// bus_dma_master: single-channel read-then-write word copy engine.
// Optional BUS_DMA_CHECKSUM_EN adds xsum, XOR of all words read.
module bus_dma_master
   import bus_dma_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int LEN_W     = LEN_W_DEF,
   parameter int ADDR_STEP = ADDR_STEP_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
`ifdef BUS_DMA_CHECKSUM_EN
   output logic [DATA_W-1:0] xsum,
`endif
   bus_dma_master_if.master  bus
);

   logic [2:0]        r_state;
   logic [2:0]        w_nxt;
   logic [DATA_W-1:0] r_buf;
   logic [ADDR_W-1:0] w_src;
   logic [ADDR_W-1:0] w_dst;
   logic              w_last;
   logic              w_accept;
   logic              w_load;
   logic              w_step;
   logic              w_cap;

   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_load   = w_accept && (len != '0);
   assign w_cap    = (r_state == ST_RDW) && bus.m_grant;
   assign w_step   = (r_state == ST_WR) && bus.m_grant;

   bus_dma_addr_cnt #(
      .ADDR_W    (ADDR_W),
      .LEN_W     (LEN_W),
      .ADDR_STEP (ADDR_STEP)
   ) u_addr_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_load),
      .i_step     (w_step),
      .i_src      (src_addr),
      .i_dst      (dst_addr),
      .i_len      (len),
      .o_src      (w_src),
      .o_dst      (w_dst),
      .o_zero_nxt (w_last)
   );

   // next state: every bus phase advances only on a granted cycle
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start) w_nxt = (len != '0) ? ST_REQ : ST_DONE;
         ST_REQ:  if (bus.m_grant) w_nxt = ST_RD;
         ST_RD:   if (bus.m_grant) w_nxt = ST_RDW;
         ST_RDW:  if (bus.m_grant) w_nxt = ST_WR;
         ST_WR:   if (bus.m_grant) w_nxt = w_last ? ST_DONE : ST_RD;
         ST_DONE: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_nxt;
   end

   // word buffer; also the write data, so it holds the last word between writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   r_buf <= '0;
      else if (w_cap) r_buf <= bus.m_din;
   end

`ifdef BUS_DMA_CHECKSUM_EN
   logic [DATA_W-1:0] r_xsum;

   // running XOR of captured words, restarted by every accepted start
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_xsum <= '0;
      else if (w_accept) r_xsum <= '0;
      else if (w_cap)    r_xsum <= r_xsum ^ bus.m_din;
   end

   assign xsum = r_xsum;
`endif

   assign bus.m_req  = (r_state == ST_REQ) || (r_state == ST_RD) ||
                       (r_state == ST_RDW) || (r_state == ST_WR);
   assign bus.m_wr   = (r_state == ST_WR);
   assign bus.m_addr = (r_state == ST_WR) ? w_dst :
                       bus.m_req          ? w_src : '0;
   assign bus.m_dout = r_buf;
   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_bus_dma_master.sv
// tb_bus_dma_master: directed plus random copy jobs against a memory model.
// Define BUS_DMA_CHECKSUM_EN to also check xsum.
module tb_bus_dma_master;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] src_addr = '0;
   logic [15:0] dst_addr = '0;
   logic [7:0]  len = '0;
   logic        busy;
   logic        done;
`ifdef BUS_DMA_CHECKSUM_EN
   logic [63:0] xsum;
`endif

   bus_dma_master_if #(.ADDR_W(16), .DATA_W(64)) bus ();

   bus_dma_master #(
      .ADDR_W(16), .DATA_W(64), .LEN_W(8), .ADDR_STEP(1)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
      .busy     (busy),
      .done     (done),
`ifdef BUS_DMA_CHECKSUM_EN
      .xsum     (xsum),
`endif
      .bus      (bus)
   );

   always #5 clk = ~clk;

   logic [63:0] mem     [0:65535];
   logic [63:0] ref_mem [0:65535];
   logic [79:0] wlog[$];
   logic [79:0] exp_q[$];
   bit          gpat [0:511];
   int          n_chk = 0;
   int          n_pass = 0;

   logic        s_req = 1'b0;
   logic        s_wr = 1'b0;
   logic        s_gnt = 1'b0;
   logic [15:0] s_addr = '0;
   logic [63:0] s_dout = '0;

   // bus slave: capture the request mid-cycle, act on it at the edge
   always @(negedge clk) begin
      s_req  = bus.m_req;
      s_wr   = bus.m_wr;
      s_gnt  = bus.m_grant;
      s_addr = bus.m_addr;
      s_dout = bus.m_dout;
   end

   always @(posedge clk) begin
      if (reset_n && s_req && s_gnt) begin
         if (s_wr) begin
            mem[s_addr] = s_dout;
            wlog.push_back({s_addr, s_dout});
         end else begin
            bus.m_din <= mem[s_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [79:0] obs,
                      input logic [79:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic preload(input logic [15:0] a, input logic [63:0] v);
      mem[a]     = v;
      ref_mem[a] = v;
   endtask

   task automatic cmp_mem(input string tag);
      int nbad;
      nbad = 0;
      for (int i = 0; i < 65536; i++)
         if (mem[i] !== ref_mem[i]) nbad++;
      chk(tag, 80'(nbad), 80'd0);
   endtask

   task automatic run_job(input string tag, input logic [15:0] s,
                          input logic [15:0] d, input logic [7:0] l,
                          input bit noise);
      logic [63:0] v;
      logic [63:0] xs;
      logic [15:0] a;
      int          need;
      int          cnt;
      int          expd;
      xs = '0;
      v  = '0;
      exp_q.delete();
      wlog.delete();
      // reference: copy word by word in order
      for (int i = 0; i < int'(l); i++) begin
         a = s + 16'(i);
         v = ref_mem[a];
         a = d + 16'(i);
         ref_mem[a] = v;
         exp_q.push_back({a, v});
         xs ^= v;
      end
      // done arrives after REQ + 3 phases per word, each needing a grant
      need = (l == 0) ? 0 : 3 * int'(l) + 1;
      expd = 0;
      cnt  = 0;
      if (need != 0) begin
         expd = 500;
         for (int k = 0; k < 500; k++) begin
            if (gpat[k]) cnt++;
            if (cnt == need) begin
               expd = k + 1;
               break;
            end
         end
      end
      @(negedge clk);
      start    = 1'b1;
      src_addr = s;
      dst_addr = d;
      len      = l;
      @(posedge clk);
      #1;
      start    = 1'b0;
      src_addr = 16'($urandom);
      dst_addr = 16'($urandom);
      len      = 8'($urandom);
      for (int k = 0; k <= expd + 1; k++) begin
         bus.m_grant = gpat[k];
         @(negedge clk);
`ifdef BUS_DMA_CHECKSUM_EN
         if (k == 0) chk({tag, "_xclr"}, 80'(xsum), 80'd0);
`endif
         chk({tag, "_ctl"}, 80'({busy, done, bus.m_req}),
             80'({k <= expd, k == expd, k < expd}));
         start = noise && (k <= expd) && ($urandom_range(1, 0) == 1);
         @(posedge clk);
         #1;
      end
      start       = 1'b0;
      bus.m_grant = 1'b1;
      chk({tag, "_nwr"}, 80'(wlog.size()), 80'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
         chk({tag, "_wr"}, wlog[i], exp_q[i]);
      if (l != 0) chk({tag, "_dhold"}, 80'(bus.m_dout), 80'(v));
`ifdef BUS_DMA_CHECKSUM_EN
      chk({tag, "_xsum"}, 80'(xsum), 80'(xs));
`endif
      cmp_mem({tag, "_mem"});
   endtask

   initial begin
      bus.m_grant = 1'b1;
      bus.m_din   = '0;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      for (int i = 0; i < 512; i++) gpat[i] = 1'b1;
      for (int i = 0; i < 32; i++) begin
         preload(16'(i), {$urandom, $urandom});
         preload(16'h7000 + 16'(i), {$urandom, $urandom});
      end

      #1;
      chk("rst_ctl", 80'({busy, done, bus.m_req, bus.m_wr}), 80'd0);
      chk("rst_addr", 80'(bus.m_addr), 80'd0);
      chk("rst_dout", 80'(bus.m_dout), 80'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // abort during the second write: only the first word lands
      wlog.delete();
      @(negedge clk);
      start    = 1'b1;
      src_addr = 16'h0000;
      dst_addr = 16'h7000;
      len      = 8'd4;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("abort_inwr", 80'(bus.m_wr), 80'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_async", 80'({busy, done, bus.m_req}), 80'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("abort_idle", 80'({busy, done, bus.m_req}), 80'd0);
      end
      ref_mem[16'h7000] = ref_mem[16'h0000];
      chk("abort_nwr", 80'(wlog.size()), 80'd1);
      if (wlog.size() > 0)
         chk("abort_wr", wlog[0], {16'h7000, ref_mem[16'h0000]});
      cmp_mem("abort_mem");

      preload(16'h0000, 64'h1111);
      run_job("single", 16'h0000, 16'h7000, 8'd1, 1'b0);

      preload(16'h7000, 64'h2222);
      preload(16'h7001, 64'h3333);
      preload(16'h7002, 64'h4444);
      run_job("multi", 16'h7000, 16'h0010, 8'd3, 1'b0);

      run_job("len0", 16'h0003, 16'h7003, 8'd0, 1'b0);

      gpat[0] = 1'b0;
      gpat[1] = 1'b0;
      gpat[2] = 1'b0;
      gpat[5] = 1'b0;
      gpat[6] = 1'b0;
      run_job("stall", 16'h0004, 16'h7010, 8'd2, 1'b1);
      for (int i = 0; i < 512; i++) gpat[i] = 1'b1;

      preload(16'h0005, 64'h2222);
      preload(16'h0006, 64'h3333);
      run_job("xsum", 16'h0005, 16'h7008, 8'd2, 1'b0);

      for (int j = 0; j < 10; j++) begin
         for (int i = 0; i < 512; i++) gpat[i] = ($urandom_range(3, 0) != 0);
         run_job("rand",
                 (($urandom_range(1, 0) == 1) ? 16'h7000 : 16'h0000)
                    + 16'($urandom_range(31, 0)),
                 (($urandom_range(1, 0) == 1) ? 16'h7000 : 16'h0000)
                    + 16'($urandom_range(31, 0)),
                 8'($urandom_range(9, 0)), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
